// File: rtl/rom_prefetch_if.sv
// rtl/rom_prefetch_if.sv - CPU fetch and flash read signal bundle for rom_prefetch.
// slave is the prefetcher's view, master is the CPU/flash side.
interface rom_prefetch_if #(
  parameter int AW = 16,
  parameter int DW = 29
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ready;
  logic          cpu_valid;
  logic [DW-1:0] cpu_data;
  logic          fl_start;
  logic [AW-1:0] fl_addr;
  logic          fl_busy;
  logic          fl_valid;
  logic [DW-1:0] fl_data;

  modport slave (
    input  cpu_req, cpu_addr, fl_busy, fl_valid, fl_data,
    output cpu_ready, cpu_valid, cpu_data, fl_start, fl_addr
  );

  modport master (
    output cpu_req, cpu_addr, fl_busy, fl_valid, fl_data,
    input  cpu_ready, cpu_valid, cpu_data, fl_start, fl_addr
  );
endinterface

// File: rtl/rom_prefetch.sv
// rtl/rom_prefetch.sv - sequential instruction prefetch FIFO in front of a flash reader.
// ROM_PREFETCH_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module rom_prefetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 29
) (
  input  logic          clk,
  input  logic          rst,
  rom_prefetch_if.slave bus
`ifdef ROM_PREFETCH_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DEMAND, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] head_addr_q, head_addr_d;
  logic          pend_q, pend_d;
  logic          cpu_valid_q, cpu_valid_d;
  logic [DW-1:0] cpu_data_q, cpu_data_d;
  logic          fl_start_q, fl_start_d;
  logic [AW-1:0] fl_addr_q, fl_addr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          cpu_ready;
  logic          hit, miss;
  logic          we;
  logic [PW-1:0] waddr;

  // pend_q: a demand read is owed but not yet launched (flash busy or old read draining)
  assign cpu_ready     = (state_q == IDLE || state_q == FETCH) && !pend_q;
  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.cpu_data  = cpu_data_q;
  assign bus.fl_start  = fl_start_q;
  assign bus.fl_addr   = fl_addr_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    head_addr_d = head_addr_q;
    pend_d      = pend_q;
    cpu_valid_d = 1'b0;
    cpu_data_d  = cpu_data_q;
    fl_start_d  = 1'b0;
    fl_addr_d   = fl_addr_q;
    we          = 1'b0;
    waddr       = rd_ptr_q + count_q[PW-1:0];
    hit         = 1'b0;
    miss        = 1'b0;

    if (cpu_ready && bus.cpu_req) begin
      if (count_q != '0 && bus.cpu_addr == head_addr_q) hit = 1'b1;
      else                                              miss = 1'b1;
    end

    if (hit) begin
      cpu_valid_d = 1'b1;
      cpu_data_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
      head_addr_d = head_addr_q + 1'b1;
      count_d     = count_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (miss || pend_q) begin
          if (miss) begin
            head_addr_d = bus.cpu_addr;
            count_d     = '0;
          end
          if (!bus.fl_busy) begin
            fl_start_d = 1'b1;
            fl_addr_d  = miss ? bus.cpu_addr : head_addr_q;
            pend_d     = 1'b0;
            state_d    = DEMAND;
          end else begin
            pend_d = 1'b1;
          end
        end else if (count_q < FULL && !bus.fl_busy) begin
          // head+count is unaffected by a same-cycle pop
          fl_start_d = 1'b1;
          fl_addr_d  = head_addr_q + AW'(count_q);
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (miss) begin
          head_addr_d = bus.cpu_addr;
          count_d     = '0;
          pend_d      = 1'b1;
          state_d     = bus.fl_valid ? IDLE : DRAIN;
        end else if (bus.fl_valid) begin
          we      = 1'b1;
          count_d = hit ? count_q : count_q + 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.fl_valid) state_d = IDLE;
      end
      DEMAND: begin
        if (bus.fl_valid) begin
          cpu_valid_d = 1'b1;
          cpu_data_d  = bus.fl_data;
          head_addr_d = head_addr_q + 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      head_addr_q <= '0;
      pend_q      <= 1'b0;
      cpu_valid_q <= 1'b0;
      cpu_data_q  <= '0;
      fl_start_q  <= 1'b0;
      fl_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      head_addr_q <= head_addr_d;
      pend_q      <= pend_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_data_q  <= cpu_data_d;
      fl_start_q  <= fl_start_d;
      fl_addr_q   <= fl_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= bus.fl_data;
  end

`ifdef ROM_PREFETCH_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 1'b1;
    if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_rom_prefetch.sv
// tb/tb_rom_prefetch.sv - scoreboard bench for rom_prefetch with a fixed-latency flash model.
module tb_rom_prefetch;
  localparam int AW  = 16;
  localparam int DW  = 29;
  localparam int LAT = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            req_cyc;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_prefetch_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ROM_PREFETCH_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  rom_prefetch #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ROM_PREFETCH_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            cv_count = 0;
  int            last_cv_cyc = 0;
  int            last_flv_cyc = 0;
  logic          prev_busy = 1'b0;
  logic [AW-1:0] start_log [$];
  exp_t          sb [$];

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[12:0] ^ 13'h0ABC, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_start(input int i);
    if (i < start_log.size()) return 32'(start_log[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // flash: one read at a time, data LAT cycles after fl_start is seen
  logic [AW-1:0] fm_addr;
  int            fm_cnt;
  initial begin
    bus.fl_busy  = 1'b0;
    bus.fl_valid = 1'b0;
    bus.fl_data  = '0;
    fm_addr      = '0;
    fm_cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.fl_valid = 1'b0;
      if (bus.fl_busy) begin
        fm_cnt--;
        if (fm_cnt == 0) begin
          bus.fl_valid = 1'b1;
          bus.fl_data  = rom_word(fm_addr);
          bus.fl_busy  = 1'b0;
        end
      end
      if (bus.fl_start) begin
        bus.fl_busy = 1'b1;
        fm_addr     = bus.fl_addr;
        fm_cnt      = LAT;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.fl_valid) last_flv_cyc = cyc;
        if (bus.fl_start) begin
          start_log.push_back(bus.fl_addr);
          chk("start_while_busy", 32'(prev_busy), 0);
        end
        if (bus.cpu_valid) begin
          cv_count++;
          last_cv_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_cpu_valid", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("cpu_data", 32'(bus.cpu_data), 32'(e.data));
            if (e.lat != 0) chk("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
          end
        end
      end
      prev_busy = bus.fl_busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input int lat);
    exp_t e;
    e.data    = rom_word(a);
    e.req_cyc = cyc;
    e.lat     = lat;
    sb.push_back(e);
  endtask

  task automatic req(input logic [AW-1:0] a, input int lat, input bit hold, output int waited);
    waited = 0;
    while (!bus.cpu_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!bus.cpu_ready) chk("req_ready_timeout", 0, 1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    push_exp(a, lat);
    tick();
    if (!hold) bus.cpu_req = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("wait_cpu_valid_timeout", 32'(sb.size()), 0);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (start_log.size() < target && n < 400) begin
      tick();
      n++;
    end
    chk("wait_fl_start_timeout", 32'(start_log.size() >= target), 1);
  endtask

  // Reset, then release with a missing request in the same cycle so it wins over prefetch
  task automatic do_reset(input logic [AW-1:0] a, input bit push);
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    tick();
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 1);
    chk("rst_cpu_valid", 32'(bus.cpu_valid), 0);
    chk("rst_fl_start", 32'(bus.fl_start), 0);
    chk("rst_cpu_data", 32'(bus.cpu_data), 0);
    chk("rst_fl_addr", 32'(bus.fl_addr), 0);
    start_log.delete();
    rst          = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    if (push) push_exp(a, 0);
    tick();
    bus.cpu_req = 1'b0;
    chk("ready_after_miss", 32'(bus.cpu_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int total_wait;
    int c0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;

    // cold miss at 0x0010 then prefetch until full
    do_reset(16'h0010, 1'b1);
    wait_sb();
    chk("demand_addr", get_start(0), 32'h0010);
    chk("miss_latency", 32'(last_cv_cyc - last_flv_cyc), 1);
    wait_starts(5);
    repeat (3 * LAT) tick();
    chk("full_no_start", 32'(start_log.size()), 5);
    for (int i = 1; i <= 4; i++) chk("prefetch_addr", get_start(i), 32'(16'h0010 + i));

    // back-to-back hits out of a full FIFO
    total_wait = 0;
    for (int i = 0; i < 4; i++) begin
      req(16'h0011 + 16'(i), 1, 1'b1, w);
      total_wait += w;
    end
    bus.cpu_req = 1'b0;
    chk("b2b_ready_drop", 32'(total_wait), 0);
    wait_sb();
`ifdef ROM_PREFETCH_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), 4);
    chk("miss_cnt", 32'(miss_cnt), 1);
`endif

    // jump while the 0x0013 prefetch is outstanding
    do_reset(16'h0010, 1'b1);
    wait_starts(4);
    chk("outstanding_0013", get_start(3), 32'h0013);
    req(16'h0100, 0, 1'b0, w);
    wait_sb();
    chk("jump_demand_addr", get_start(4), 32'h0100);
    wait_starts(7);
    chk("jump_prefetch_addr", get_start(5), 32'h0101);
    req(16'h0101, 1, 1'b0, w);
    wait_sb();

    // address wrap
    do_reset(16'hFFFF, 1'b1);
    wait_sb();
    wait_starts(3);
    chk("wrap_demand", get_start(0), 32'hFFFF);
    chk("wrap_pf0", get_start(1), 32'h0000);
    chk("wrap_pf1", get_start(2), 32'h0001);
    req(16'h0000, 1, 1'b0, w);
    wait_sb();

    // reset during DEMAND, stale flash data must be dropped
    do_reset(16'h0200, 1'b0);
    repeat (3) tick();
    c0 = cv_count;
    rst = 1'b1;
    start_log.delete();
    tick();
    rst = 1'b0;
`ifdef ROM_PREFETCH_STATS_EN
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
`endif
    repeat (20) tick();
    chk("no_cv_after_rst", 32'(cv_count), 32'(c0));
    wait_starts(2);
    chk("post_rst_prefetch", get_start(0), 32'h0000);
    req(16'h0000, 1, 1'b0, w);
    wait_sb();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
